// File: rtl/canvas_pkg.sv
// Shared canvas geometry, reader state encoding and address helpers.
package canvas_pkg;

  localparam int CANVAS_DIM   = 32;
  localparam int CANVAS_CELLS = CANVAS_DIM * CANVAS_DIM;
  localparam int ADDR_W       = 10;
  localparam int COORD_W      = ADDR_W / 2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SCAN,
    DRAIN,
    FIN
  } canvas_rd_state_t;

  // addr = {y, x}
  function automatic logic [COORD_W-1:0] addr_x(input logic [ADDR_W-1:0] addr);
    return addr[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] addr_y(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:COORD_W];
  endfunction

endpackage

// File: rtl/canvas_reader_if.sv
// Bit-stream valid/ready interface from the canvas reader to its consumer.
interface canvas_reader_if;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_last;

  modport master (output out_valid, output out_bit, output out_last, input out_ready);
  modport slave  (input out_valid, input out_bit, input out_last, output out_ready);
endinterface

// File: rtl/canvas_reader_fifo.sv
// canvas_bit_fifo: 2-entry {last,bit} FIFO with occupancy output and synchronous flush.
module canvas_bit_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic [1:0] head,
  output logic [1:0] occ
);

  logic [1:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && (occ != 2'd2);
  assign do_pop  = pop && (occ != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/canvas_reader.sv
// Scans the 32x32 canvas in address order, streams each bit, and reports pixel count / bbox.
// Bounding-box tracking is built only when CANVAS_READER_BBOX_EN is defined.
//
// state | meaning
// IDLE  | waiting; start sets the pending flag
// ARM   | waiting for editing to drop, then clear accumulators
// SCAN  | issuing reads 0..1023, throttled by FIFO level
// DRAIN | waiting for the out_last handshake
// FIN   | latch results, pulse done
module canvas_reader
  import canvas_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               editing,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_data,
  canvas_reader_if.master    so,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    pix_count,
  output logic [COORD_W-1:0] bbox_x_min,
  output logic [COORD_W-1:0] bbox_x_max,
  output logic [COORD_W-1:0] bbox_y_min,
  output logic [COORD_W-1:0] bbox_y_max,
  output logic               empty
);

  canvas_rd_state_t  state, state_nxt;
  logic              pending;
  logic              editing_q;
  logic              inflight;
  logic              last_q;
  logic              acc_clear;
  logic              pop;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   acc_count;
  logic [1:0]        occ;
  logic [1:0]        head;
  logic [2:0]        level;

  assign so.out_valid = (occ != 2'd0);
  assign so.out_bit   = head[0];
  assign so.out_last  = head[1];
  assign pop          = so.out_valid & so.out_ready;
  assign rd_addr      = addr_cnt;

  // Occupancy after this cycle's pop, plus the read still in flight; keeps 1 bit/cycle at full rate.
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  canvas_bit_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (acc_clear),
    .push      (inflight),
    .push_data ({last_q, rd_data}),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    acc_clear = 1'b0;
    case (state)
      IDLE: begin
        if (pending) state_nxt = ARM;
      end
      ARM: begin
        busy = 1'b1;
        if (!editing_q) begin
          acc_clear = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy  = 1'b1;
        rd_en = (level < 3'd2);
        if (rd_en && (addr_cnt == ADDR_W'(CANVAS_CELLS - 1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && so.out_last) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      editing_q <= 1'b0;
      inflight  <= 1'b0;
      last_q    <= 1'b0;
      addr_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      editing_q <= editing;
      inflight  <= rd_en;
      last_q    <= rd_en && (addr_cnt == ADDR_W'(CANVAS_CELLS - 1));
      if (state != IDLE) pending <= 1'b0;
      else if (start)    pending <= 1'b1;
      if (acc_clear)  addr_cnt <= '0;
      else if (rd_en) addr_cnt <= addr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || acc_clear) begin
      acc_count <= '0;
    end else if (inflight && rd_data && (acc_count != (ADDR_W+1)'(CANVAS_CELLS))) begin
      acc_count <= acc_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_count <= '0;
      empty     <= 1'b1;
    end else if (state == FIN) begin
      pix_count <= acc_count;
      empty     <= (acc_count == '0);
    end
  end

`ifdef CANVAS_READER_BBOX_EN
  logic [ADDR_W-1:0]  addr_q;
  logic [COORD_W-1:0] x_min_acc, x_max_acc, y_min_acc, y_max_acc;
  logic [COORD_W-1:0] cur_x, cur_y;

  assign cur_x = addr_x(addr_q);
  assign cur_y = addr_y(addr_q);

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else if (rd_en) addr_q <= addr_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst || acc_clear) begin
      x_min_acc <= COORD_W'(CANVAS_DIM - 1);
      y_min_acc <= COORD_W'(CANVAS_DIM - 1);
      x_max_acc <= '0;
      y_max_acc <= '0;
    end else if (inflight && rd_data) begin
      if (cur_x < x_min_acc) x_min_acc <= cur_x;
      if (cur_x > x_max_acc) x_max_acc <= cur_x;
      if (cur_y < y_min_acc) y_min_acc <= cur_y;
      if (cur_y > y_max_acc) y_max_acc <= cur_y;
    end
  end

  // An empty scan reports a zero box rather than the inverted running extremes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bbox_x_min <= '0;
      bbox_x_max <= '0;
      bbox_y_min <= '0;
      bbox_y_max <= '0;
    end else if (state == FIN) begin
      bbox_x_min <= (acc_count == '0) ? '0 : x_min_acc;
      bbox_x_max <= (acc_count == '0) ? '0 : x_max_acc;
      bbox_y_min <= (acc_count == '0) ? '0 : y_min_acc;
      bbox_y_max <= (acc_count == '0) ? '0 : y_max_acc;
    end
  end
`else
  assign bbox_x_min = '0;
  assign bbox_y_min = '0;
  assign bbox_x_max = COORD_W'(CANVAS_DIM - 1);
  assign bbox_y_max = COORD_W'(CANVAS_DIM - 1);
`endif

endmodule

// File: tb/tb_canvas_reader.sv
// Directed bench for canvas_reader: RAM model, stream scoreboard and result model from the memory image.
module tb_canvas_reader;
  import canvas_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               editing;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_data = 1'b0;
  logic               busy;
  logic               done;
  logic [ADDR_W:0]    pix_count;
  logic [COORD_W-1:0] bx0, bx1, by0, by1;
  logic               empty;

  canvas_reader_if sif ();

  canvas_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .editing    (editing),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .so         (sif),
    .busy       (busy),
    .done       (done),
    .pix_count  (pix_count),
    .bbox_x_min (bx0),
    .bbox_x_max (bx1),
    .bbox_y_min (by0),
    .bbox_y_max (by1),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  logic mem [CANVAS_CELLS];

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int checks = 0;
  int errors = 0;
  int issued, hs, done_cnt, cyc, last_hs_cyc, done_cyc;
  bit prev_stall, prev_bit, prev_last;
  int ready_mode = 0;
  int rcyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Per-cycle scoreboard, sampled at the falling edge.
  task automatic compare_cycle();
    cyc++;
    if (rst) begin
      issued = 0;
      hs = 0;
      prev_stall = 1'b0;
    end else begin
      if (rd_en) begin
        chk("rd_addr_order", int'(rd_addr), issued);
        issued++;
      end
      if (prev_stall) begin
        chk("stall_valid", int'(sif.out_valid), 1);
        chk("stall_bit", int'(sif.out_bit), int'(prev_bit));
        chk("stall_last", int'(sif.out_last), int'(prev_last));
      end
      if (ready_mode == 0 && hs > 0 && hs < CANVAS_CELLS)
        chk("full_rate_valid", int'(sif.out_valid), 1);
      if (sif.out_valid && sif.out_ready) begin
        if (hs < CANVAS_CELLS) begin
          chk("stream_bit", int'(sif.out_bit), int'(mem[hs]));
          chk("stream_last", int'(sif.out_last), (hs == CANVAS_CELLS - 1) ? 1 : 0);
        end else begin
          chk("extra_handshake", hs, CANVAS_CELLS - 1);
        end
        if (sif.out_last) last_hs_cyc = cyc;
        hs++;
      end
      chk("outstanding_le2", (issued - hs <= 2) ? 1 : 0, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_bit   = sif.out_bit;
      prev_last  = sif.out_last;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    rcyc++;
    sif.out_ready = (ready_mode == 0) ? 1'b1 : (((rcyc / 3) % 2) == 0);
  endtask

  task automatic model_summary(output int cnt, output int x0, output int x1,
                               output int y0, output int y1);
    cnt = 0; x0 = 31; x1 = 0; y0 = 31; y1 = 0;
    for (int a = 0; a < CANVAS_CELLS; a++) begin
      if (mem[a]) begin
        cnt++;
        if (a % 32 < x0) x0 = a % 32;
        if (a % 32 > x1) x1 = a % 32;
        if (a / 32 < y0) y0 = a / 32;
        if (a / 32 > y1) y1 = a / 32;
      end
    end
`ifdef CANVAS_READER_BBOX_EN
    if (cnt == 0) begin x0 = 0; x1 = 0; y0 = 0; y1 = 0; end
`else
    x0 = 0; x1 = 31; y0 = 0; y1 = 31;
`endif
  endtask

  task automatic check_bbox(input string name, input int x0, input int x1,
                            input int y0, input int y1);
    chk({name, "_x_min"}, int'(bx0), x0);
    chk({name, "_x_max"}, int'(bx1), x1);
    chk({name, "_y_min"}, int'(by0), y0);
    chk({name, "_y_max"}, int'(by1), y1);
  endtask

  task automatic begin_scan();
    hs = 0; issued = 0; done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_scan();
    int n, cnt, x0, x1, y0, y1;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      tick();
      n++;
    end
    chk("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    repeat (4) tick();
    chk("done_once", done_cnt, 1);
    chk("handshakes", hs, CANVAS_CELLS);
    chk("reads_issued", issued, CANVAS_CELLS);
    chk("done_latency", done_cyc - last_hs_cyc, 1);
    chk("busy_after_done", int'(busy), 0);
    model_summary(cnt, x0, x1, y0, y1);
    chk("pix_count", int'(pix_count), cnt);
    chk("empty", int'(empty), (cnt == 0) ? 1 : 0);
    check_bbox("bbox", x0, x1, y0, y1);
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < CANVAS_CELLS; a++) mem[a] = (((a * 37) >> 3) % 2) == 1;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; editing = 1'b0; sif.out_ready = 1'b1;
    for (int a = 0; a < CANVAS_CELLS; a++) mem[a] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(sif.out_valid), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_pix", int'(pix_count), 0);
    chk("rst_empty", int'(empty), 1);
`ifdef CANVAS_READER_BBOX_EN
    check_bbox("rst", 0, 0, 0, 0);
`else
    check_bbox("rst", 0, 31, 0, 31);
`endif

    // All-zero canvas
    begin_scan();
    finish_scan();
    chk("t1_pix", int'(pix_count), 0);
    chk("t1_empty", int'(empty), 1);

    // Single pixel at 0x3A5
    mem[933] = 1'b1;
    begin_scan();
    finish_scan();
    chk("t2_pix", int'(pix_count), 1);
    chk("t2_empty", int'(empty), 0);
`ifdef CANVAS_READER_BBOX_EN
    check_bbox("t2", 5, 5, 29, 29);
`else
    check_bbox("t2", 0, 31, 0, 31);
`endif

    // Two pixels (2,3) and (30,17)
    mem[933] = 1'b0;
    mem[3 * 32 + 2] = 1'b1;
    mem[17 * 32 + 30] = 1'b1;
    begin_scan();
    finish_scan();
    chk("t3_pix", int'(pix_count), 2);
`ifdef CANVAS_READER_BBOX_EN
    check_bbox("t3", 2, 30, 3, 17);
`else
    check_bbox("t3", 0, 31, 0, 31);
`endif

    // Backpressure: ready toggles every 3 cycles
    fill_pattern();
    ready_mode = 1;
    rcyc = 0;
    begin_scan();
    finish_scan();
    ready_mode = 0;
    sif.out_ready = 1'b1;

    // start while editing
    for (int a = 0; a < CANVAS_CELLS; a++) mem[a] = (a % 5 == 0) || (a == 1023);
    editing = 1'b1;
    begin_scan();
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("no_rd_while_editing", int'(rd_en), 0);
    end
    chk("busy_in_arm", int'(busy), 1);
    editing = 1'b0;
    tick();
    chk("rd_en_fall_plus1", int'(rd_en), 0);
    tick();
    chk("rd_en_fall_plus2", int'(rd_en), 1);
    finish_scan();
    chk("t5_pix", int'(pix_count), 206);

    // rst at handshake 500
    fill_pattern();
    begin_scan();
    n = 0;
    while (hs < 500 && n < 3000) begin
      tick();
      n++;
    end
    chk("reached_hs500", hs, 500);
    rst = 1'b1;
    tick();
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(sif.out_valid), 0);
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_pix", int'(pix_count), 0);
    chk("abort_empty", int'(empty), 1);
`ifdef CANVAS_READER_BBOX_EN
    check_bbox("abort", 0, 0, 0, 0);
`else
    check_bbox("abort", 0, 31, 0, 31);
`endif
    rst = 1'b0;
    done_cnt = 0;
    repeat (20) tick();
    chk("no_done_after_abort", done_cnt, 0);
    chk("idle_after_abort", int'(busy), 0);
    begin_scan();
    finish_scan();

    // start together with rst
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    repeat (5) tick();
    chk("rst_wins_busy", int'(busy), 0);
    chk("rst_wins_rd_en", int'(rd_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
